load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the single-cycle datapath and the word-only data memory (async read, sync write, word index = address[31:2]). Adds byte and halfword loads with sign or zero extension, and byte and halfword stores. Sub-word stores are done as a two-cycle read-modify-write, during which the core is stalled. Misaligned accesses are flagged and never reach memory.

## Interface
- No parameters. Data width is fixed at 32 bits and byte order is little-endian.
- clk  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high.
- req  in  1  Access request. Sampled only while busy=0.
- op  in  4  op[3] = store, op[2] = unsigned (loads only), op[1:0] = size (00 byte, 01 half, 10 word; 11 is illegal).
- addr  in  32  Byte address.
- wdata  in  32  Store data; the low byte or halfword is used for sub-word stores.
- busy  out  1  High while in MERGE; the core must stall and hold its inputs.
- done  out  1  Registered one-cycle pulse marking completion of an accepted request.
- rdata  out  32  Registered load result, valid when done=1 for a load.
- fault  out  1  Registered pulse together with done, for a misaligned or illegal op.
- mem_addr  out  32  Address to the data memory.
- mem_wdata  out  32  Write data to the data memory.
- mem_write  out  1  Write enable to the data memory.
- mem_rdata  in  32  Combinational read data from the data memory.

## Operation
- States are IDLE and MERGE. busy = (state == MERGE).
- A request is accepted in a cycle with state == IDLE, req = 1 and reset = 0.
- Fault check runs at acceptance:
  - size 11 is illegal;
  - a half access requires addr[0] = 0;
  - a word access requires addr[1:0] = 00.
  - On a fault: no mem_write, rdata is held, and done = fault = 1 on the next cycle.
- Lane k = addr[1:0] selects bits [8k+7:8k]. Half lane h = addr[1] selects bits [16h+15:16h].
- Load (LB, LBU, LH, LHU, LW):
  - mem_addr = addr;
  - the selected lane of mem_rdata is sign-extended (op[2] = 0) or zero-extended (op[2] = 1) and registered into rdata;
  - done = 1 on the next cycle. State stays IDLE.
- SW: mem_write = 1 and mem_wdata = wdata in the acceptance cycle. done = 1 on the next cycle.
- SB/SH:
  - In the acceptance cycle, latch the word-aligned address and mem_rdata with the target lane replaced by wdata[7:0] or wdata[15:0] into a merge register. mem_write = 0. Go to MERGE.
  - In MERGE: mem_addr = the latched address, mem_wdata = the merge register, mem_write = 1. Return to IDLE. done = 1 on the next cycle.
- mem_write is combinational from state and req/op. It is 0 in IDLE whenever no SW is being accepted, and 0 whenever reset = 1.
- In IDLE with no request, mem_addr = addr and mem_wdata = wdata, so the datapath can read through.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, fault = 0, rdata = 0x00000000, merge register = 0.
- Latency from acceptance to done: 1 cycle for loads, SW and faults; 2 cycles for SB/SH.
- done and fault are high for exactly one cycle per accepted request and never without one.
- A new req in the same cycle that done is high is accepted (back-to-back, no bubble). The done of a load and the acceptance of the next request can coincide.
- req while busy = 1 is ignored, with no side effects.
- Reset asserted in MERGE aborts the operation: no write is issued, the state goes to IDLE, and no done follows.
- Reset takes priority over req in the same cycle.
- The merge captures mem_rdata at acceptance. The core guarantees no other writer to the data memory between acceptance and MERGE.

## Test plan
- Word round trip: SW addr=0x10, wdata=0xDEADBEEF; then LW addr=0x10 → mem_write for 1 cycle at acceptance, then rdata=0xDEADBEEF with done one cycle after the LW is accepted.
- Byte store merge: SB addr=0x11, wdata=0x000000AA onto word 0x11223344 → busy for 1 cycle, MERGE writes 0x1122AA44, done on the following cycle. LB addr=0x11 then gives 0xFFFFFFAA; LBU gives 0x000000AA.
- Halfword extension: word 0x8001_7FFF. LH addr=0x22 → 0xFFFF8001; LHU addr=0x22 → 0x00008001; LH addr=0x20 → 0x00007FFF.
- Faults: LW addr=0x02, SH addr=0x03 and op=0011 → each gives done = fault = 1 after 1 cycle, mem_write never asserted, rdata unchanged.
- Back-to-back and stall: SB, then LW held on req during busy → the LW is accepted only in the cycle after MERGE and returns the merged word. req during busy causes no extra done.
- Reset in MERGE: SB accepted, reset=1 in the MERGE cycle → no mem_write, no done, outputs at reset values, memory word unchanged.

Source files
------------

// File: rtl/lsu_if.sv
// lsu_if: core-side request/response and data-memory port of the load/store unit
interface lsu_if;
  logic        req;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;
  modport slave (
    input  req, op, addr, wdata, mem_rdata,
    output busy, done, rdata, fault, mem_addr, mem_wdata, mem_write
  );
  modport master (
    output req, op, addr, wdata, mem_rdata,
    input  busy, done, rdata, fault, mem_addr, mem_wdata, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: sub-word loads/stores over a word-only memory; SB/SH via two-cycle read-modify-write
module load_store_unit (
  input logic clk,
  input logic reset,
  lsu_if.slave bus
);
  typedef enum logic {IDLE, MERGE} state_t;
  state_t      state;
  logic [31:0] merge_addr, merge_data, load_val, merged, lane_mask, lane_data, rd_shift;
  logic [1:0]  size;
  logic [4:0]  sh;
  logic        accept, misal, is_sw, sgn;
  always_comb begin
    size       = bus.op[1:0];
    accept     = state == IDLE && bus.req && !reset;
    misal      = size == 2'b11 || (size == 2'b01 && bus.addr[0]) || (size == 2'b10 && bus.addr[1:0] != 2'b00);
    is_sw      = bus.op[3] && size == 2'b10;
    sh         = size == 2'b01 ? {bus.addr[1], 4'b0000} : {bus.addr[1:0], 3'b000};
    rd_shift   = bus.mem_rdata >> sh;
    sgn        = !bus.op[2] && (size == 2'b00 ? rd_shift[7] : rd_shift[15]);
    load_val   = size == 2'b00 ? {{24{sgn}}, rd_shift[7:0]} :
                 size == 2'b01 ? {{16{sgn}}, rd_shift[15:0]} : bus.mem_rdata;
    lane_mask  = (size == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    lane_data  = (size == 2'b00 ? {24'b0, bus.wdata[7:0]} : {16'b0, bus.wdata[15:0]}) << sh;
    merged     = (bus.mem_rdata & ~lane_mask) | lane_data;
    bus.mem_write = !reset && (state == MERGE || (accept && !misal && is_sw));
    bus.mem_addr  = state == MERGE ? merge_addr : bus.addr;
    bus.mem_wdata = state == MERGE ? merge_data : bus.wdata;
    bus.busy      = state == MERGE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state      <= IDLE;
      bus.done   <= 1'b0;
      bus.fault  <= 1'b0;
      bus.rdata  <= 32'h0;
      merge_addr <= 32'h0;
      merge_data <= 32'h0;
    end else begin
      bus.done  <= 1'b0;
      bus.fault <= 1'b0;
      if (state == MERGE) begin
        state    <= IDLE;
        bus.done <= 1'b1;
      end else if (accept) begin
        if (misal) begin
          bus.done  <= 1'b1;
          bus.fault <= 1'b1;
        end else if (!bus.op[3]) begin
          bus.rdata <= load_val;
          bus.done  <= 1'b1;
        end else if (is_sw) begin
          bus.done <= 1'b1;
        end else begin
          merge_addr <= {bus.addr[31:2], 2'b00};
          merge_data <= merged;
          state      <= MERGE;
        end
      end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized transactions scored against a byte-addressed memory model
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  lsu_if bus();
  load_store_unit dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] mem [64];
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  logic [7:0]  sh [256];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          started = 0;
  bit          rst_q = 0;
  bit          exp_done [int];
  bit          exp_fault [int];
  logic [31:0] exp_rd [int];
  logic [31:0] exp_wd [int];
  logic [31:0] exp_wa [int];
  logic [31:0] rdata_m = 32'h0;
  bit          ed, ew;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask
  function automatic logic [31:0] word(input logic [31:0] a);
    logic [7:0] w = {a[7:2], 2'b00};
    return {sh[w + 8'd3], sh[w + 8'd2], sh[w + 8'd1], sh[w]};
  endfunction
  function automatic logic [31:0] ld(input logic [3:0] o, input logic [31:0] a);
    int nb = 1 << o[1:0];
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = sh[a[7:0] + 8'(i)];
    if (!o[2] && nb < 4 && v[8*nb-1])
      for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hff;
    return v;
  endfunction
  // Every cycle after reset: done/fault/writes must match exactly what the transaction log scheduled.
  always @(negedge clk) if (started) begin
    ed = exp_done.exists(cyc);
    ew = exp_wd.exists(cyc);
    if (rst_q) rdata_m = 32'h0;
    if (exp_rd.exists(cyc)) rdata_m = exp_rd[cyc];
    chk("done", 32'(bus.done), 32'(ed));
    chk("fault", 32'(bus.fault), ed ? 32'(exp_fault[cyc]) : 32'd0);
    chk("mem_write", 32'(bus.mem_write), 32'(ew));
    if (ew) begin
      chk("mem_addr", bus.mem_addr, exp_wa[cyc]);
      chk("mem_wdata", bus.mem_wdata, exp_wd[cyc]);
    end
    chk("rdata", bus.rdata, rdata_m);
  end
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] res, output bit f);
    int n = 0;
    int nb = 1 << o[1:0];
    bus.req = 1'b1; bus.op = o; bus.addr = a; bus.wdata = d;
    while (bus.busy && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) chk("busy_timeout", 32'(bus.busy), 32'd0);
    f   = o[1:0] == 2'b11 || (int'(a[1:0]) % nb) != 0;
    res = 32'h0;
    if (f) begin
      exp_done[cyc+1] = 1; exp_fault[cyc+1] = 1;
    end else if (!o[3]) begin
      res = ld(o, a);
      exp_done[cyc+1] = 1; exp_fault[cyc+1] = 0; exp_rd[cyc+1] = res;
    end else begin
      for (int i = 0; i < nb; i++) sh[a[7:0] + 8'(i)] = d[8*i +: 8];
      res = word(a);
      if (nb == 4) begin
        exp_wd[cyc] = res; exp_wa[cyc] = a;
        exp_done[cyc+1] = 1; exp_fault[cyc+1] = 0;
      end else begin
        exp_wd[cyc+1] = res; exp_wa[cyc+1] = {a[31:2], 2'b00};
        exp_done[cyc+2] = 1; exp_fault[cyc+2] = 0;
      end
    end
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask
  task automatic idle(input int n);
    bus.req = 1'b0; bus.addr = $urandom; bus.wdata = $urandom; bus.op = 4'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] r, t, old;
    bit f;
    reset = 1'b1; bus.req = 1'b0; bus.op = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
    for (int i = 0; i < 256; i++) sh[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    started = 1;
    reset = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    for (int i = 0; i < 64; i++) begin
      t = $urandom;
      do_op(4'b1010, {t[31:8], 6'(i), 2'b00}, $urandom, r, f);
    end
    do_op(4'b1010, 32'h10, 32'hDEADBEEF, r, f);
    do_op(4'b0010, 32'h10, 32'h0, r, f);
    chk("lw_roundtrip", r, 32'hDEADBEEF);
    do_op(4'b1010, 32'h10, 32'h11223344, r, f);
    do_op(4'b1000, 32'h11, 32'h000000AA, r, f);
    chk("sb_merge_word", r, 32'h1122AA44);
    do_op(4'b0010, 32'h10, 32'h0, r, f);
    chk("lw_after_sb", r, 32'h1122AA44);
    do_op(4'b0000, 32'h11, 32'h0, r, f);
    chk("lb_signed", r, 32'hFFFFFFAA);
    do_op(4'b0100, 32'h11, 32'h0, r, f);
    chk("lbu", r, 32'h000000AA);
    do_op(4'b1010, 32'h20, 32'h80017FFF, r, f);
    do_op(4'b0001, 32'h22, 32'h0, r, f);
    chk("lh_hi", r, 32'hFFFF8001);
    do_op(4'b0101, 32'h22, 32'h0, r, f);
    chk("lhu_hi", r, 32'h00008001);
    do_op(4'b0001, 32'h20, 32'h0, r, f);
    chk("lh_lo", r, 32'h00007FFF);
    do_op(4'b1001, 32'h22, 32'h0000BEEF, r, f);
    chk("sh_merge_word", r, 32'hBEEF7FFF);
    do_op(4'b0010, 32'h02, 32'h0, r, f);
    chk("fault_lw", 32'(f), 32'd1);
    do_op(4'b1001, 32'h03, 32'h1234, r, f);
    chk("fault_sh", 32'(f), 32'd1);
    do_op(4'b0011, 32'h04, 32'h0, r, f);
    chk("fault_op11", 32'(f), 32'd1);
    for (int k = 0; k < 300; k++) begin
      do_op(4'($urandom), $urandom, $urandom, r, f);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    // Abort a sub-word store by resetting in its merge cycle.
    idle(2);
    old = word(32'h30);
    bus.req = 1'b1; bus.op = 4'b1000; bus.addr = 32'h31; bus.wdata = 32'h55;
    @(posedge clk); #1;
    chk("rm_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1; bus.req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rm_busy_after", 32'(bus.busy), 32'd0);
    chk("rm_done", 32'(bus.done), 32'd0);
    chk("rm_fault", 32'(bus.fault), 32'd0);
    chk("rm_rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;
    chk("rm_no_late_done", 32'(bus.done), 32'd0);
    chk("rm_mem", mem[12], old);
    idle(2);
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], word(32'(i * 4)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
